vector_op_scheduler: RTL and testbench

//   Shares one pipelined 3-lane vector ALU (add/sub/double/negate) between NREQ

---
 rtl/vector_op_scheduler.sv | 158 +++++++++++++++
 tb/tb_vector_op_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_op_scheduler.sv
// vector_op_scheduler
//   Shares one pipelined 3-lane vector ALU between NREQ requesters. A
//   round-robin arbiter picks at most one requester per cycle. The chosen op
//   is computed on entry and carried down a LAT-deep pipeline. The last stage
//   drives a single tagged response channel that can be backpressured.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous reset, active low
//     req_valid  per-requester request valid            [NREQ]
//     req_ready  per-requester accept, one-hot or zero  [NREQ]
//     req_op     op of requester i at [2*i+:2]          [2*NREQ]
//     req_a      operand A of requester i at [96*i+:96] [96*NREQ]
//     req_b      operand B of requester i at [96*i+:96] [96*NREQ]
//     rsp_valid  result valid
//     rsp_ready  consumer accepts result
//     rsp_id     requester index that issued the result [IDW]
//     rsp_r      result vector, lane k at [32*k+:32]    [96]
//     busy       any pipeline stage holds a valid op
//
//   Ops (per 32-bit lane, wrapping): 00 a+b, 01 a-b, 10 a<<<1, 11 -a
module vector_op_scheduler #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [2*NREQ-1:0]  req_op,
  input  logic [96*NREQ-1:0] req_a,
  input  logic [96*NREQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [95:0]        rsp_r,
  output logic               busy
);

  logic [LAT-1:0] stage_valid;
  logic [IDW-1:0] stage_id [LAT];
  logic [95:0]    stage_r  [LAT];

  logic [IDW-1:0] rr_ptr;
  logic           advance;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic           transfer;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;
  logic [1:0]     sel_op;
  logic [95:0]    sel_a;
  logic [95:0]    sel_b;
  logic [95:0]    alu_r;

  // Per-lane ALU; each lane wraps independently modulo 2^32.
  function automatic logic [95:0] vec_alu(input logic [1:0]  op,
                                          input logic [95:0] a,
                                          input logic [95:0] b);
    logic [95:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      case (op)
        2'b00:   r[32*k+:32] = a[32*k+:32] + b[32*k+:32];
        2'b01:   r[32*k+:32] = a[32*k+:32] - b[32*k+:32];
        2'b10:   r[32*k+:32] = a[32*k+:32] <<< 1;
        default: r[32*k+:32] = 32'd0 - a[32*k+:32];
      endcase
    end
    return r;
  endfunction

  // The whole pipe moves as one; it only stalls when the output holds a
  // result the consumer has not taken yet.
  assign advance = !stage_valid[LAT-1] || rsp_ready;

  // Round-robin scan starting at rr_ptr. The index is wrapped explicitly so
  // non-power-of-two NREQ never selects a requester that does not exist.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign transfer = advance && grant_found;

  // Drive ready onto the granted requester and pick its operands with
  // constant slices, keeping the mux free of computed part-selects.
  always_comb begin
    req_ready = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    if (transfer) begin
      req_ready[grant_idx] = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_op = req_op[2*i+:2];
        sel_a  = req_a[96*i+:96];
        sel_b  = req_b[96*i+:96];
      end
    end
  end

  assign alu_r = vec_alu(sel_op, sel_a, sel_b);

  // The pointer moves just past the winner, so the winner has lowest
  // priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Stage 0 captures the finished ALU result on entry. Later stages only
  // delay it, so the output comes straight from registers. A cycle with no
  // transfer inserts a bubble rather than collapsing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int i = 0; i < LAT; i++) begin
        stage_id[i] <= '0;
        stage_r[i]  <= '0;
      end
    end else if (advance) begin
      stage_valid[0] <= transfer;
      stage_id[0]    <= grant_idx;
      stage_r[0]     <= alu_r;
      for (int i = 1; i < LAT; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_id[i]    <= stage_id[i-1];
        stage_r[i]     <= stage_r[i-1];
      end
    end
  end

  assign rsp_valid = stage_valid[LAT-1];
  assign rsp_id    = stage_id[LAT-1];
  assign rsp_r     = stage_r[LAT-1];
  assign busy      = |stage_valid;

endmodule

// File: tb/tb_vector_op_scheduler.sv
// Directed testbench for vector_op_scheduler (NREQ=4, LAT=2).
// Inputs are driven 1ns after the rising edge. Outputs are sampled there too,
// which keeps sampling away from the active edge.
module tb_vector_op_scheduler;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IDW  = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_op;
  logic [96*NREQ-1:0] req_a;
  logic [96*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [95:0]        rsp_r;
  logic               busy;

  int total;
  int bad;

  vector_op_scheduler #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_r     (rsp_r),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] vec(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return {z, y, x};
  endfunction

  task automatic set_req(input int id, input logic [1:0] op,
                         input logic [95:0] a, input logic [95:0] b);
    req_op[2*id+:2] = op;
    req_a[96*id+:96] = a;
    req_b[96*id+:96] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    #2;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    total++; if (rsp_r !== 96'd0) begin bad++; $display("[TB] FAIL reset_rsp_r got=%h exp=0", rsp_r); end
    total++; if (dut.rr_ptr !== 2'd0) begin bad++; $display("[TB] FAIL reset_rr_ptr got=%0d exp=0", dut.rr_ptr); end
    tick();
    rst_n = 1'b1;
    tick();
    // two ops in flight, held by rsp_ready=0
    set_req(0, 2'b00, vec(1, 1, 1), vec(1, 1, 1));
    set_req(1, 2'b00, vec(2, 2, 2), vec(2, 2, 2));
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    total++; if (busy !== 1'b1 || rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL inflight got busy=%b valid=%b exp 1/1", busy, rsp_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
    total++; if (dut.rr_ptr !== 2'd0) begin bad++; $display("[TB] FAIL midreset_rr_ptr got=%0d exp=0", dut.rr_ptr); end
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_ghost got valid=%b busy=%b exp 0/0", rsp_valid, busy); end
    end
  endtask

  task automatic test_ops();
    logic [95:0] a;
    logic [95:0] b;
    logic [95:0] exp_r [4];
    a = vec(32'd1, 32'hFFFF_FFFE, 32'h7FFF_FFFF);
    b = vec(32'd3, 32'd5, 32'd1);
    exp_r[0] = vec(32'd4, 32'd3, 32'h8000_0000);
    exp_r[1] = vec(32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'h7FFF_FFFE);
    exp_r[2] = vec(32'd2, 32'hFFFF_FFFC, 32'hFFFF_FFFE);
    exp_r[3] = vec(32'hFFFF_FFFF, 32'd2, 32'h8000_0001);
    rsp_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      set_req(0, 2'(op), a, b);
      req_valid = 4'b0001;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL ops_ready op=%0d got=%b exp=0001", op, req_ready); end
      tick();
      req_valid = 4'b0000;
      for (int w = 0; w < LAT-1; w++) begin
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL ops_early op=%0d got=%b exp=0", op, rsp_valid); end
        tick();
      end
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL ops_valid op=%0d got=%b exp=1", op, rsp_valid); end
      total++; if (rsp_id !== 2'd0) begin bad++; $display("[TB] FAIL ops_id op=%0d got=%0d exp=0", op, rsp_id); end
      total++; if (rsp_r !== exp_r[op]) begin bad++; $display("[TB] FAIL ops_result op=%0d got=%h exp=%h", op, rsp_r, exp_r[op]); end
    end
    tick();
  endtask

  task automatic test_fairness();
    int exp_q[$];
    int got;
    int id;
    do_reset();
    rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 2'b00, vec(32'(i+1), 32'(i+2), 32'(i+3)), vec(32'd100, 32'd200, 32'd300));
    end
    for (int cyc = 0; cyc < 8 + LAT + 2; cyc++) begin
      req_valid = (cyc < 8) ? 4'hF : 4'h0;
      #1;
      if (cyc < 8) begin
        total++; if (req_ready !== 4'(1 << (cyc % 4))) begin bad++; $display("[TB] FAIL fair_grant cyc=%0d got=%b exp=%b", cyc, req_ready, 4'(1 << (cyc % 4))); end
        exp_q.push_back(cyc % 4);
      end
      tick();
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("[TB] FAIL fair_extra got id=%0d exp=none", rsp_id);
        end else begin
          id = exp_q.pop_front();
          got++;
          total++; if (rsp_id !== 2'(id)) begin bad++; $display("[TB] FAIL fair_id got=%0d exp=%0d", rsp_id, id); end
          total++; if (rsp_r !== vec(32'(id+101), 32'(id+202), 32'(id+303))) begin bad++; $display("[TB] FAIL fair_r got=%h exp=%h", rsp_r, vec(32'(id+101), 32'(id+202), 32'(id+303))); end
        end
      end
    end
    total++; if (got !== 8) begin bad++; $display("[TB] FAIL fair_count got=%0d exp=8", got); end
  endtask

  task automatic test_skip_wrap();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("[TB] FAIL wrap_setup got=%b exp=0100", req_ready); end
    tick();
    total++; if (dut.rr_ptr !== 2'd3) begin bad++; $display("[TB] FAIL wrap_ptr3 got=%0d exp=3", dut.rr_ptr); end
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL wrap_skip got=%b exp=0010", req_ready); end
    tick();
    total++; if (dut.rr_ptr !== 2'd2) begin bad++; $display("[TB] FAIL wrap_ptr2 got=%0d exp=2", dut.rr_ptr); end
    req_valid = 4'b0101;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("[TB] FAIL wrap_pick2 got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_backpressure();
    logic [95:0] r0;
    logic [95:0] r1;
    r0 = vec(32'd9, 32'd19, 32'd29);
    r1 = vec(32'd6, 32'd8, 32'd10);
    rsp_ready = 1'b0;
    set_req(0, 2'b01, vec(32'd10, 32'd20, 32'd30), vec(32'd1, 32'd1, 32'd1));
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL bp_fill0 got=%b exp=0001", req_ready); end
    tick();
    set_req(0, 2'b00, vec(32'd5, 32'd6, 32'd7), vec(32'd1, 32'd2, 32'd3));
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL bp_fill1 got=%b exp=0001", req_ready); end
    tick();
    set_req(0, 2'b10, vec(32'd77, 32'd77, 32'd77), vec(32'd0, 32'd0, 32'd0));
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL bp_ready c=%0d got=%b exp=0000", c, req_ready); end
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_r !== r0) begin bad++; $display("[TB] FAIL bp_hold c=%0d got=%b/%0d/%h exp=1/0/%h", c, rsp_valid, rsp_id, rsp_r, r0); end
      tick();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b1 || rsp_r !== r0) begin bad++; $display("[TB] FAIL bp_drain0 got=%b/%h exp=1/%h", rsp_valid, rsp_r, r0); end
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_r !== r1) begin bad++; $display("[TB] FAIL bp_drain1 got=%b/%h exp=1/%h", rsp_valid, rsp_r, r1); end
    tick();
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty got=%b/%b exp=0/0", rsp_valid, busy); end
  endtask

  task automatic test_back_to_back();
    int sent;
    int got;
    bit started;
    sent = 0;
    got = 0;
    started = 1'b0;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 100 + LAT + 3; cyc++) begin
      if (sent < 100) begin
        req_valid = 4'b0001;
        set_req(0, 2'b00, vec(32'(sent), 32'(sent), 32'(sent)), vec(32'(sent), 32'd0, 32'd0));
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (sent < 100) begin
        total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL b2b_ready n=%0d got=%b exp=0001", sent, req_ready); end
      end
      tick();
      if (sent < 100) sent++;
      if (rsp_valid) begin
        started = 1'b1;
        total++; if (rsp_r !== vec(32'(2*got), 32'(got), 32'(got))) begin bad++; $display("[TB] FAIL b2b_r n=%0d got=%h exp=%h", got, rsp_r, vec(32'(2*got), 32'(got), 32'(got))); end
        got++;
      end else if (started && got < 100) begin
        total++; bad++; $display("[TB] FAIL b2b_gap n=%0d got=0 exp=1", got);
      end
    end
    total++; if (got !== 100) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=100", got); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_ops();
    test_fairness();
    test_skip_wrap();
    test_backpressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
